lane_id_tracker: RTL and testbench

- Registered successor to the one-hot lane ID decoder, one instance per physical lane of the 100GbE PCS receive path.
- Takes the per-AM-slot match mask from the N_ALIGNER alignment-marker comparators and decodes it to a binary logical lane ID.
- Rejects zero-hit and multi-hit masks.
- Locks the physical-to-logical mapping only after LOCK_COUNT consecutive identical valid IDs.
- Drops lock after UNLOCK_COUNT consecutive bad AM slots.
- Feeds the lane reorder/deskew stage.

---
 rtl/lane_id_tracker.sv | 199 +++++++++++++++++++
 tb/tb_lane_id_tracker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lane_id_tracker.sv
// Lane ID tracker: decodes the per-AM-slot comparator match mask to a binary
// logical lane ID and locks the physical-to-logical mapping once the same ID
// has been seen on enough consecutive AM slots. Lock is dropped after enough
// consecutive bad slots. All outputs are registered.
module lane_id_tracker #(
  parameter int N_ALIGNER    = 20,
  parameter int ID_LEN       = $clog2(N_ALIGNER),
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_LEN      = $clog2(((LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT) + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_am_valid,
  input  logic [N_ALIGNER-1:0] i_match_mask,
  output logic [ID_LEN-1:0]    o_lane_id,
  output logic                 o_lock,
  output logic                 o_id_change,
  output logic                 o_no_hit,
  output logic                 o_multi_hit
);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  localparam logic [CNT_LEN-1:0] LOCK_CNT_C   = CNT_LEN'(LOCK_COUNT);
  localparam logic [CNT_LEN-1:0] UNLOCK_CNT_C = CNT_LEN'(UNLOCK_COUNT);
  localparam logic [CNT_LEN-1:0] CNT_ONE_C    = CNT_LEN'(1);
  localparam logic [CNT_LEN-1:0] CNT_ZERO_C   = {CNT_LEN{1'b0}};
  localparam logic [CNT_LEN-1:0] CNT_MAX_C    = {CNT_LEN{1'b1}};

  // Number of set mask bits, saturated at 2 (0 = no hit, 1 = good, 2 = multi).
  function automatic logic [1:0] hit_count(input logic [N_ALIGNER-1:0] mask);
    logic [1:0] cnt;
    cnt = 2'd0;
    for (int k = 0; k < N_ALIGNER; k++) begin
      if (mask[k] && (cnt != 2'd2)) begin
        cnt = cnt + 2'd1;
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  // Index of the set bit; only meaningful when exactly one bit is set.
  function automatic logic [ID_LEN-1:0] hit_index(input logic [N_ALIGNER-1:0] mask);
    logic [ID_LEN-1:0] idx;
    idx = {ID_LEN{1'b0}};
    for (int k = 0; k < N_ALIGNER; k++) begin
      if (mask[k]) begin
        idx = ID_LEN'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Saturating counter increment: never wraps back to zero.
  function automatic logic [CNT_LEN-1:0] sat_inc(input logic [CNT_LEN-1:0] v);
    return (v == CNT_MAX_C) ? v : (v + CNT_ONE_C);
  endfunction

  state_t              state_r, state_s;
  logic [ID_LEN-1:0]   candidate_r, candidate_s;
  logic [CNT_LEN-1:0]  match_cnt_r, match_cnt_s;
  logic [CNT_LEN-1:0]  miss_cnt_r, miss_cnt_s;
  logic [CNT_LEN-1:0]  inc_s;
  logic [ID_LEN-1:0]   lane_id_r, lane_id_s;
  logic                lock_r, lock_s;
  logic                id_change_r, id_change_s;
  logic                no_hit_r, no_hit_s;
  logic                multi_hit_r, multi_hit_s;

  logic                event_s;
  logic [1:0]          hits_s;
  logic                good_s;
  logic [ID_LEN-1:0]   id_s;

  assign event_s = i_enable & i_am_valid;
  assign hits_s  = hit_count(i_match_mask);
  assign good_s  = (hits_s == 2'd1);
  assign id_s    = hit_index(i_match_mask);

  // Next-state and next-output computation for the lock FSM.
  always_comb begin
    state_s     = state_r;
    candidate_s = candidate_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    lane_id_s   = lane_id_r;
    id_change_s = 1'b0;
    no_hit_s    = 1'b0;
    multi_hit_s = 1'b0;
    inc_s       = CNT_ZERO_C;
    if (event_s) begin
      no_hit_s    = (hits_s == 2'd0);
      multi_hit_s = (hits_s == 2'd2);
      case (state_r)
        ST_UNLOCKED: begin
          if (good_s) begin
            candidate_s = id_s;
            match_cnt_s = CNT_ONE_C;
            if (LOCK_CNT_C <= CNT_ONE_C) begin
              state_s     = ST_LOCKED;
              lane_id_s   = id_s;
              miss_cnt_s  = CNT_ZERO_C;
              id_change_s = (id_s != lane_id_r);
            end else begin
              state_s = ST_CANDIDATE;
            end
          end else begin
            state_s = ST_UNLOCKED;
          end
        end
        ST_CANDIDATE: begin
          if (good_s && (id_s == candidate_r)) begin
            inc_s       = sat_inc(match_cnt_r);
            match_cnt_s = inc_s;
            if (inc_s >= LOCK_CNT_C) begin
              state_s     = ST_LOCKED;
              lane_id_s   = candidate_r;
              miss_cnt_s  = CNT_ZERO_C;
              id_change_s = (candidate_r != lane_id_r);
            end else begin
              state_s = ST_CANDIDATE;
            end
          end else if (good_s) begin
            candidate_s = id_s;
            match_cnt_s = CNT_ONE_C;
          end else begin
            state_s     = ST_UNLOCKED;
            match_cnt_s = CNT_ZERO_C;
          end
        end
        ST_LOCKED: begin
          if (good_s && (id_s == lane_id_r)) begin
            miss_cnt_s = CNT_ZERO_C;
          end else begin
            // A different good ID is treated exactly like a bad slot.
            inc_s = sat_inc(miss_cnt_r);
            if (inc_s >= UNLOCK_CNT_C) begin
              state_s     = ST_UNLOCKED;
              match_cnt_s = CNT_ZERO_C;
              miss_cnt_s  = CNT_ZERO_C;
            end else begin
              miss_cnt_s = inc_s;
            end
          end
        end
        default: begin
          state_s     = ST_UNLOCKED;
          match_cnt_s = CNT_ZERO_C;
          miss_cnt_s  = CNT_ZERO_C;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    lock_s = (state_s == ST_LOCKED);
  end

  // State and output registers; synchronous reset dominates the enable.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r     <= ST_UNLOCKED;
      candidate_r <= {ID_LEN{1'b0}};
      match_cnt_r <= CNT_ZERO_C;
      miss_cnt_r  <= CNT_ZERO_C;
      lane_id_r   <= {ID_LEN{1'b0}};
      lock_r      <= 1'b0;
      id_change_r <= 1'b0;
      no_hit_r    <= 1'b0;
      multi_hit_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      candidate_r <= candidate_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      lane_id_r   <= lane_id_s;
      lock_r      <= lock_s;
      id_change_r <= id_change_s;
      no_hit_r    <= no_hit_s;
      multi_hit_r <= multi_hit_s;
    end
  end

  assign o_lane_id   = lane_id_r;
  assign o_lock      = lock_r;
  assign o_id_change = id_change_r;
  assign o_no_hit    = no_hit_r;
  assign o_multi_hit = multi_hit_r;

endmodule

// File: tb/tb_lane_id_tracker.sv
// Self-checking bench for lane_id_tracker: directed vector table, hand-written
// lock/unlock sequences, then randomized traffic against a streak-based model.
module tb_lane_id_tracker;

  localparam int N_ALIGNER    = 20;
  localparam int ID_LEN       = 5;
  localparam int LOCK_COUNT   = 4;
  localparam int UNLOCK_COUNT = 3;

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b0;
  logic                 i_enable = 1'b0;
  logic                 i_am_valid = 1'b0;
  logic [N_ALIGNER-1:0] i_match_mask = '0;
  logic [ID_LEN-1:0]    o_lane_id;
  logic                 o_lock, o_id_change, o_no_hit, o_multi_hit;

  int n_cmp = 0;
  int n_fail = 0;

  lane_id_tracker #(
    .N_ALIGNER(N_ALIGNER), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_am_valid(i_am_valid),
    .i_match_mask(i_match_mask), .o_lane_id(o_lane_id), .o_lock(o_lock),
    .o_id_change(o_id_change), .o_no_hit(o_no_hit), .o_multi_hit(o_multi_hit)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the run of identical good IDs and the run of
  // misses since lock, computed straight from the lock/unlock rules.
  int   m_locked = 0, m_lane = 0, m_streak_id = 0, m_streak_len = 0, m_miss = 0;
  logic e_idc = 1'b0, e_nh = 1'b0, e_mh = 1'b0;

  function automatic void model_step(input logic rst, input logic en, input logic av,
                                     input logic [N_ALIGNER-1:0] mask);
    int n;
    int id;
    e_idc = 1'b0; e_nh = 1'b0; e_mh = 1'b0;
    if (rst) begin
      m_locked = 0; m_lane = 0; m_streak_id = 0; m_streak_len = 0; m_miss = 0;
    end else if (en && av) begin
      n  = $countones(mask);
      id = -1;
      for (int k = 0; k < N_ALIGNER; k++) if (mask[k] && id < 0) id = k;
      e_nh = (n == 0);
      e_mh = (n > 1);
      if (m_locked == 0) begin
        if (n == 1) begin
          if (m_streak_len > 0 && id == m_streak_id) m_streak_len++;
          else begin m_streak_id = id; m_streak_len = 1; end
          if (m_streak_len >= LOCK_COUNT) begin
            m_locked = 1; e_idc = (id != m_lane); m_lane = id; m_miss = 0;
          end
        end else m_streak_len = 0;
      end else begin
        if (n == 1 && id == m_lane) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss >= UNLOCK_COUNT) begin m_locked = 0; m_streak_len = 0; m_miss = 0; end
        end
      end
    end
  endfunction

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, return 1 time unit later so outputs can be sampled.
  task automatic cycle(input logic rst, input logic en, input logic av,
                       input logic [N_ALIGNER-1:0] mask);
    @(negedge clk);
    i_reset = rst; i_enable = en; i_am_valid = av; i_match_mask = mask;
    @(posedge clk);
    model_step(rst, en, av, mask);
    #1;
  endtask

  task automatic check(input string name, input int lane, input logic lock,
                       input logic idc, input logic nh, input logic mh);
    n_cmp++;
    if (int'(o_lane_id) != lane || o_lock !== lock || o_id_change !== idc ||
        o_no_hit !== nh || o_multi_hit !== mh) begin
      n_fail++;
      $display("FAIL %s: got lane=%0d lock=%0b idc=%0b nh=%0b mh=%0b, expected lane=%0d lock=%0b idc=%0b nh=%0b mh=%0b",
               name, o_lane_id, o_lock, o_id_change, o_no_hit, o_multi_hit, lane, lock, idc, nh, mh);
    end
  endtask

  typedef struct {
    string                name;
    logic                 rst, en, av;
    logic [N_ALIGNER-1:0] mask;
    int                   lane;
    logic                 lock, idc, nh, mh;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input logic rst, input logic en, input logic av,
                              input logic [N_ALIGNER-1:0] mask, input int lane,
                              input logic lock, input logic idc, input logic nh, input logic mh);
    vec_t v;
    v.name = nm; v.rst = rst; v.en = en; v.av = av; v.mask = mask;
    v.lane = lane; v.lock = lock; v.idc = idc; v.nh = nh; v.mh = mh;
    vecs.push_back(v);
  endfunction

  logic [N_ALIGNER-1:0] one_c;
  logic [N_ALIGNER-1:0] rmask;
  int fav;
  int a, b;

  initial begin
    one_c = {{(N_ALIGNER-1){1'b0}}, 1'b1};
    // 1: reset, then lock on 7
    add("reset", 1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add("t1_cand", 1'b0, 1'b1, 1'b1, one_c << 7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("t1_lock", 1'b0, 1'b1, 1'b1, one_c << 7, 7, 1'b1, 1'b1, 1'b0, 1'b0);
    add("t1_idle", 1'b0, 1'b1, 1'b0, '0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    // 2: two misses then a good slot keep lock
    add("t2_good", 1'b0, 1'b1, 1'b1, one_c << 7, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    add("t2_nohit", 1'b0, 1'b1, 1'b1, '0, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    add("t2_other", 1'b0, 1'b1, 1'b1, one_c << 3, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    add("t2_recov", 1'b0, 1'b1, 1'b1, one_c << 7, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    // 3: three multi-hit slots unlock
    add("t3_multi1", 1'b0, 1'b1, 1'b1, 20'h00030, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    add("t3_multi2", 1'b0, 1'b1, 1'b1, 20'h00030, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    add("t3_unlock", 1'b0, 1'b1, 1'b1, 20'h00030, 7, 1'b0, 1'b0, 1'b0, 1'b1);
    // 4: candidate restart, lock on the top index
    add("t4_c2a", 1'b0, 1'b1, 1'b1, one_c << 2, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    add("t4_c2b", 1'b0, 1'b1, 1'b1, one_c << 2, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add("t4_c19", 1'b0, 1'b1, 1'b1, one_c << 19, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    add("t4_lock19", 1'b0, 1'b1, 1'b1, one_c << 19, 19, 1'b1, 1'b1, 1'b0, 1'b0);
    // 5: unlock, then disabled strobes are ignored, then lock on 5
    add("t5_nh1", 1'b0, 1'b1, 1'b1, '0, 19, 1'b1, 1'b0, 1'b1, 1'b0);
    add("t5_nh2", 1'b0, 1'b1, 1'b1, '0, 19, 1'b1, 1'b0, 1'b1, 1'b0);
    add("t5_nh3", 1'b0, 1'b1, 1'b1, '0, 19, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add("t5_disabled", 1'b0, 1'b0, 1'b1, one_c << 5, 19, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add("t5_cand", 1'b0, 1'b1, 1'b1, one_c << 5, 19, 1'b0, 1'b0, 1'b0, 1'b0);
    add("t5_lock5", 1'b0, 1'b1, 1'b1, one_c << 5, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    // 6: reset with a concurrent strobe clears everything
    add("t6_reset", 1'b1, 1'b1, 1'b1, one_c << 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("t6_after", 1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("t6_unlocked", 1'b0, 1'b1, 1'b1, one_c << 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].av, vecs[i].mask);
      check(vecs[i].name, vecs[i].lane, vecs[i].lock, vecs[i].idc, vecs[i].nh, vecs[i].mh);
    end

    // Hand sequence: finish locking on 5, then different good IDs unlock it.
    cycle(1'b0, 1'b1, 1'b1, one_c << 5); check("h_c2", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, one_c << 5); check("h_c3", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, one_c << 5); check("h_lock5", 5, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, one_c << 9); check("h_miss1", 5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, one_c << 9); check("h_miss2", 5, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, one_c << 9); check("h_unlock", 5, 1'b0, 1'b0, 1'b0, 1'b0);
    // Hand sequence: lock on 0, then reset with enable low still clears lock.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, one_c); check("h_c0", 5, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b1, 1'b1, one_c); check("h_lock0", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0); check("h_rst_noen", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    fav = 7;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) fav = $urandom_range(0, N_ALIGNER - 1);
      case ($urandom_range(0, 9))
        0: rmask = '0;
        1: begin
          a = $urandom_range(0, N_ALIGNER - 1);
          b = (a + 1 + $urandom_range(0, N_ALIGNER - 2)) % N_ALIGNER;
          rmask = (one_c << a) | (one_c << b);
        end
        2: rmask = one_c << $urandom_range(0, N_ALIGNER - 1);
        default: rmask = one_c << fav;
      endcase
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) != 0), rmask);
      check("rand", m_lane, (m_locked != 0), e_idc, e_nh, e_mh);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
